// File: rtl/riscv_mem_arbiter_if.sv
// Request/response bundle between the riscv32i masters, the arbiter and the memory bus.
// Per-master fields are flattened, master i at [i*W +: W].
interface riscv_mem_arbiter_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_MASTERS = 2
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_we;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS*BE_W-1:0]   m_be;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS-1:0]        m_rvalid;
    logic [DATA_W-1:0]             m_rdata;
    logic [NUM_MASTERS-1:0]        m_err;

    logic                          bus_valid;
    logic                          bus_ready;
    logic                          bus_we;
    logic [ADDR_W-1:0]             bus_addr;
    logic [DATA_W-1:0]             bus_wdata;
    logic [BE_W-1:0]               bus_be;
    logic                          bus_rvalid;
    logic [DATA_W-1:0]             bus_rdata;

    // Arbiter side
    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_gnt, m_rvalid, m_rdata, m_err,
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    // Masters plus memory side
    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_gnt, m_rvalid, m_rdata, m_err,
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Round-robin shared-memory arbiter: one outstanding valid/ready transaction,
// bus timeout and zero-byte-enable access faults reported back to the owner.
module riscv_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input logic                clk,
    input logic                reset,
    riscv_mem_arbiter_if.slave mif
);
    localparam int          BE_W  = DATA_W / 8;
    localparam int          PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [15:0] TMO   = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, FAULT} state_t;

    state_t                 state, state_nxt;
    logic [PTR_W-1:0]       rr_ptr, owner, win_idx;
    logic                   win_found;
    int                     scan_idx;
    logic                   accept;
    logic                   timed_out;
    logic [15:0]            cnt;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [BE_W-1:0]        sel_be;

    logic                   req_we_p0;
    logic [ADDR_W-1:0]      req_addr_p0;
    logic [DATA_W-1:0]      req_wdata_p0;
    logic [BE_W-1:0]        req_be_p0;

    logic [NUM_MASTERS-1:0] vld_p1;
    logic [DATA_W-1:0]      rdata_p1;

    // First requester at or after rr_ptr, scanning upward with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_MASTERS;
            if (!win_found && mif.m_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // No grant while the previous response pulse is still on the wire
    assign accept    = (state == IDLE) && win_found && (vld_p1 == '0) && !reset;
    assign sel_be    = mif.m_be[int'(win_idx)*BE_W +: BE_W];
    assign timed_out = (cnt == TMO);
    assign owner_oh  = NUM_MASTERS'(1) << owner;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (sel_be != '0) ? ADDR : FAULT;
            end
            ADDR: begin
                if (timed_out)          state_nxt = FAULT;
                else if (mif.bus_ready) state_nxt = RESP;
            end
            RESP: begin
                if (mif.bus_rvalid)     state_nxt = IDLE;
                else if (timed_out)     state_nxt = FAULT;
            end
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            cnt          <= '0;
            req_we_p0    <= 1'b0;
            req_addr_p0  <= '0;
            req_wdata_p0 <= '0;
            req_be_p0    <= '0;
            vld_p1       <= '0;
            rdata_p1     <= '0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= '0;

            // p0: request fields captured at grant, held for the whole bus phase
            if (accept) begin
                owner        <= win_idx;
                rr_ptr       <= PTR_W'((int'(win_idx) + 1) % NUM_MASTERS);
                req_we_p0    <= mif.m_we[win_idx];
                req_addr_p0  <= mif.m_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                req_wdata_p0 <= mif.m_wdata[int'(win_idx)*DATA_W +: DATA_W];
                req_be_p0    <= sel_be;
            end

            if (state == IDLE)
                cnt <= '0;
            else if (state == ADDR || state == RESP)
                cnt <= cnt + 16'd1;

            // p1: response registered, delivered to the owner one cycle later
            if (state == RESP && mif.bus_rvalid) begin
                rdata_p1 <= mif.bus_rdata;
                vld_p1   <= owner_oh;
            end else if (state_nxt == FAULT && state != FAULT) begin
                rdata_p1 <= '0;
            end
        end
    end

    assign mif.m_gnt     = accept ? (NUM_MASTERS'(1) << win_idx) : '0;
    assign mif.m_rvalid  = vld_p1 | ((state == FAULT) ? owner_oh : '0);
    assign mif.m_err     = (state == FAULT) ? owner_oh : '0;
    assign mif.m_rdata   = rdata_p1;

    assign mif.bus_valid = (state == ADDR);
    assign mif.bus_we    = req_we_p0;
    assign mif.bus_addr  = req_addr_p0;
    assign mif.bus_wdata = req_wdata_p0;
    assign mif.bus_be    = req_be_p0;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: per-cycle vector table plus hand sequences
// for delayed handshakes, timeout and mid-transaction reset.
module tb_riscv_mem_arbiter;
    localparam int AW = 32, DW = 32, NM = 2, TMO_B = 8;
    localparam logic       L = 1'b0, H = 1'b1;
    localparam logic [1:0] N2 = 2'b00, M0 = 2'b01, M1 = 2'b10, BOTH = 2'b11;
    localparam logic [31:0] A0 = 32'h0000_0100, A1 = 32'h0000_0200, NA = 32'h0, NR = 32'h0;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    always #5 clk = ~clk;

    riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_MASTERS(NM)) ifa ();
    riscv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_MASTERS(NM)) ifb ();

    riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_MASTERS(NM), .TIMEOUT(255))
        dut_a (.clk(clk), .reset(reset_a), .mif(ifa.slave));
    riscv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_MASTERS(NM), .TIMEOUT(TMO_B))
        dut_b (.clk(clk), .reset(reset_b), .mif(ifb.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic rst; logic [1:0] req; logic zb; logic rdy; logic rv; logic [31:0] rdata;
        logic [1:0] gnt; logic [1:0] rvl; logic [1:0] err; logic bv; logic [31:0] baddr;
        logic chk; logic [31:0] mrd;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [1:0] req, input logic zb, input logic rdy,
                       input logic rv, input logic [31:0] rdata, input logic [1:0] gnt,
                       input logic [1:0] rvl, input logic [1:0] err, input logic bv,
                       input logic [31:0] baddr, input logic chk, input logic [31:0] mrd);
        vec_t r;
        r.rst = rst; r.req = req; r.zb = zb; r.rdy = rdy; r.rv = rv; r.rdata = rdata;
        r.gnt = gnt; r.rvl = rvl; r.err = err; r.bv = bv; r.baddr = baddr; r.chk = chk; r.mrd = mrd;
        vecs.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_read(input logic [1:0] who, input logic [31:0] addr, input logic [31:0] rd,
                          input string nm);
        ifb.m_req = who; ifb.bus_ready = 1'b0; ifb.bus_rvalid = 1'b0;
        @(negedge clk);
        check({nm, "_gnt"}, 128'(ifb.m_gnt), 128'(who));
        tick();
        ifb.m_req = N2; ifb.bus_ready = 1'b1;
        @(negedge clk);
        check({nm, "_bus"}, 128'({ifb.bus_valid, ifb.bus_addr}), 128'({H, addr}));
        tick();
        ifb.bus_ready = 1'b0; ifb.bus_rvalid = 1'b1; ifb.bus_rdata = rd;
        tick();
        ifb.bus_rvalid = 1'b0; ifb.bus_rdata = 32'h0;
        @(negedge clk);
        check({nm, "_rsp"}, 128'({ifb.m_rvalid, ifb.m_err, ifb.m_rdata}), 128'({who, N2, rd}));
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bv_cnt, rv_cnt, err_cnt, rv_cyc, fault_cyc;
        logic [36:0] snap;

        // single read, master 0
        add(L, M0, L, L, L, NR, M0, N2, N2, L, NA, L, NR);
        add(L, N2, L, H, L, NR, N2, N2, N2, H, A0, L, NR);
        add(L, N2, L, L, H, 32'hDEAD_BEEF, N2, N2, N2, L, NA, L, NR);
        add(L, N2, L, L, L, NR, N2, M0, N2, L, NA, H, 32'hDEAD_BEEF);
        add(L, N2, L, L, L, NR, N2, N2, N2, L, NA, L, NR);
        // both masters requesting continuously after reset: 0,1,0,1
        add(H, N2, L, L, L, NR, N2, N2, N2, L, NA, L, NR);
        add(L, BOTH, L, L, L, NR, M0, N2, N2, L, NA, L, NR);
        add(L, BOTH, L, H, L, NR, N2, N2, N2, H, A0, L, NR);
        add(L, BOTH, L, L, H, 32'h1111_1111, N2, N2, N2, L, NA, L, NR);
        add(L, BOTH, L, L, L, NR, N2, M0, N2, L, NA, H, 32'h1111_1111);
        add(L, BOTH, L, L, L, NR, M1, N2, N2, L, NA, L, NR);
        add(L, BOTH, L, H, L, NR, N2, N2, N2, H, A1, L, NR);
        add(L, BOTH, L, L, H, 32'h2222_2222, N2, N2, N2, L, NA, L, NR);
        add(L, BOTH, L, L, L, NR, N2, M1, N2, L, NA, H, 32'h2222_2222);
        add(L, BOTH, L, L, L, NR, M0, N2, N2, L, NA, L, NR);
        add(L, BOTH, L, H, L, NR, N2, N2, N2, H, A0, L, NR);
        add(L, BOTH, L, L, H, 32'h3333_3333, N2, N2, N2, L, NA, L, NR);
        add(L, BOTH, L, L, L, NR, N2, M0, N2, L, NA, H, 32'h3333_3333);
        add(L, BOTH, L, L, L, NR, M1, N2, N2, L, NA, L, NR);
        add(L, N2, L, H, L, NR, N2, N2, N2, H, A1, L, NR);
        add(L, N2, L, L, H, 32'h4444_4444, N2, N2, N2, L, NA, L, NR);
        add(L, N2, L, L, L, NR, N2, M1, N2, L, NA, H, 32'h4444_4444);
        // after reset master 1 alone is granted at once; then collision goes to master 0
        add(H, N2, L, L, L, NR, N2, N2, N2, L, NA, L, NR);
        add(L, M1, L, L, L, NR, M1, N2, N2, L, NA, L, NR);
        add(L, N2, L, H, L, NR, N2, N2, N2, H, A1, L, NR);
        add(L, N2, L, L, H, 32'h5555_5555, N2, N2, N2, L, NA, L, NR);
        add(L, N2, L, L, L, NR, N2, M1, N2, L, NA, H, 32'h5555_5555);
        add(L, BOTH, L, L, L, NR, M0, N2, N2, L, NA, L, NR);
        add(L, M1, L, H, L, NR, N2, N2, N2, H, A0, L, NR);
        add(L, M1, L, L, H, 32'h6666_6666, N2, N2, N2, L, NA, L, NR);
        add(L, M1, L, L, L, NR, N2, M0, N2, L, NA, H, 32'h6666_6666);
        add(L, M1, L, L, L, NR, M1, N2, N2, L, NA, L, NR);
        add(L, N2, L, H, L, NR, N2, N2, N2, H, A1, L, NR);
        add(L, N2, L, L, H, 32'h7777_7777, N2, N2, N2, L, NA, L, NR);
        add(L, N2, L, L, L, NR, N2, M1, N2, L, NA, H, 32'h7777_7777);
        // zero-be write from master 1; stray bus handshakes during the fault are ignored
        add(L, M1, H, L, L, NR, M1, N2, N2, L, NA, L, NR);
        add(L, N2, L, H, H, 32'h9999_9999, N2, M1, M1, L, NA, H, NR);
        add(L, M0, L, L, L, NR, M0, N2, N2, L, NA, L, NR);
        add(L, N2, L, H, L, NR, N2, N2, N2, H, A0, L, NR);
        add(L, N2, L, L, H, 32'h8888_8888, N2, N2, N2, L, NA, L, NR);
        add(L, N2, L, L, L, NR, N2, M0, N2, L, NA, H, 32'h8888_8888);

        reset_a = 1'b1; reset_b = 1'b1;
        ifa.m_req = N2; ifa.m_we = N2; ifa.m_addr = {A1, A0};
        ifa.m_wdata = {32'hB1B1_0001, 32'hA0A0_0000}; ifa.m_be = 8'hFF;
        ifa.bus_ready = 1'b0; ifa.bus_rvalid = 1'b0; ifa.bus_rdata = 32'h0;
        ifb.m_req = N2; ifb.m_we = N2; ifb.m_addr = {32'h0000_0400, 32'h0000_0500};
        ifb.m_wdata = 64'h0; ifb.m_be = 8'hFF;
        ifb.bus_ready = 1'b0; ifb.bus_rvalid = 1'b0; ifb.bus_rdata = 32'h0;
        tick();
        tick();
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);
        check("reset_a_ctl", 128'({ifa.m_gnt, ifa.m_rvalid, ifa.m_err, ifa.bus_valid, ifa.bus_we, ifa.bus_be}), 128'(0));
        check("reset_a_data", 128'({ifa.bus_addr, ifa.bus_wdata, ifa.m_rdata}), 128'(0));
        check("reset_b_ctl", 128'({ifb.m_gnt, ifb.m_rvalid, ifb.m_err, ifb.bus_valid, ifb.bus_we, ifb.bus_be}), 128'(0));
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            reset_a = vecs[i].rst;
            ifa.m_req = vecs[i].req;
            ifa.m_we = vecs[i].zb ? M1 : N2;
            ifa.m_be = {(vecs[i].zb ? 4'h0 : 4'hF), 4'hF};
            ifa.bus_ready = vecs[i].rdy; ifa.bus_rvalid = vecs[i].rv; ifa.bus_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), 128'({ifa.m_gnt, ifa.m_rvalid, ifa.m_err, ifa.bus_valid}),
                  128'({vecs[i].gnt, vecs[i].rvl, vecs[i].err, vecs[i].bv}));
            if (vecs[i].bv)
                check($sformatf("vec%0d_addr", i), 128'(ifa.bus_addr), 128'(vecs[i].baddr));
            if (vecs[i].chk)
                check($sformatf("vec%0d_rdata", i), 128'(ifa.m_rdata), 128'(vecs[i].mrd));
            tick();
        end
        ifa.m_we = N2; ifa.m_be = 8'hFF;

        // delayed handshake: write from master 0, ready on the 6th ADDR cycle, rvalid 4 cycles later
        ifa.m_req = M0; ifa.m_we = M0; ifa.m_addr[31:0] = 32'h0000_0300;
        ifa.m_wdata[31:0] = 32'hCAFE_F00D; ifa.m_be[3:0] = 4'h3;
        ifa.bus_ready = 1'b0; ifa.bus_rvalid = 1'b0; ifa.bus_rdata = 32'hFEED_FACE;
        @(negedge clk);
        check("dly_gnt", 128'(ifa.m_gnt), 128'(M0));
        tick();
        ifa.m_req = N2;
        bv_cnt = 0; rv_cnt = 0; err_cnt = 0; rv_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            ifa.bus_ready = (c == 6);
            ifa.bus_rvalid = (c == 10);
            @(negedge clk);
            if (ifa.bus_valid) begin
                bv_cnt++;
                check($sformatf("dly_fields_c%0d", c), 128'({ifa.bus_we, ifa.bus_addr, ifa.bus_wdata, ifa.bus_be}),
                      128'({H, 32'h0000_0300, 32'hCAFE_F00D, 4'h3}));
            end
            if (ifa.m_rvalid != N2) begin
                rv_cnt++;
                rv_cyc = c;
                check("dly_rvalid_owner", 128'(ifa.m_rvalid), 128'(M0));
            end
            if (ifa.m_err != N2) err_cnt++;
            tick();
        end
        check("dly_bv_cycles", 128'(bv_cnt), 128'(6));
        check("dly_rvalid_count", 128'(rv_cnt), 128'(1));
        check("dly_rvalid_cycle", 128'(rv_cyc), 128'(11));
        check("dly_err_count", 128'(err_cnt), 128'(0));
        ifa.bus_ready = 1'b0; ifa.bus_rvalid = 1'b0;
        ifa.m_we = N2; ifa.m_addr = {A1, A0}; ifa.m_wdata = {32'hB1B1_0001, 32'hA0A0_0000}; ifa.m_be = 8'hFF;

        // reset while in RESP aborts the transaction and clears rr_ptr
        ifa.m_req = M0;
        @(negedge clk);
        check("rst_gnt", 128'(ifa.m_gnt), 128'(M0));
        tick();
        ifa.m_req = N2; ifa.bus_ready = 1'b1;
        tick();
        ifa.bus_ready = 1'b0;
        tick();
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0; ifa.bus_rvalid = 1'b1; ifa.bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check("rst_ctl", 128'({ifa.m_gnt, ifa.m_rvalid, ifa.m_err, ifa.bus_valid, ifa.bus_we, ifa.bus_be}), 128'(0));
        check("rst_data", 128'({ifa.bus_addr, ifa.bus_wdata, ifa.m_rdata}), 128'(0));
        tick();
        ifa.bus_rvalid = 1'b0;
        @(negedge clk);
        check("rst_no_rvalid", 128'({ifa.m_rvalid, ifa.m_err}), 128'(0));
        tick();
        ifa.m_req = BOTH;
        @(negedge clk);
        check("rst_rr_gnt", 128'(ifa.m_gnt), 128'(M0));
        tick();
        ifa.m_req = N2; ifa.bus_ready = 1'b1;
        tick();
        ifa.bus_ready = 1'b0; ifa.bus_rvalid = 1'b1; ifa.bus_rdata = 32'h0000_00AA;
        tick();
        ifa.bus_rvalid = 1'b0;
        @(negedge clk);
        check("rst_after_rsp", 128'({ifa.m_rvalid, ifa.m_err, ifa.m_rdata}), 128'({M0, N2, 32'h0000_00AA}));
        tick();

        // timeout on dut_b (TIMEOUT=8): neither ready nor rvalid ever arrives
        b_read(M1, 32'h0000_0400, 32'hABCD_1234, "b_pre");
        ifb.m_req = M1;
        @(negedge clk);
        check("to_gnt", 128'(ifb.m_gnt), 128'(M1));
        tick();
        ifb.m_req = N2;
        bv_cnt = 0; fault_cyc = -1; snap = '0; err_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (ifb.bus_valid) bv_cnt++;
            if (ifb.m_err != N2) err_cnt++;
            if (ifb.m_rvalid != N2 && fault_cyc < 0) begin
                fault_cyc = c;
                snap = {ifb.m_rvalid, ifb.m_err, ifb.m_rdata, ifb.bus_valid};
            end
            tick();
        end
        check("to_fault_cycle", 128'(fault_cyc), 128'(TMO_B + 2));
        check("to_bv_cycles", 128'(bv_cnt), 128'(TMO_B + 1));
        check("to_fault_outputs", 128'(snap), 128'({M1, M1, 32'h0, L}));
        check("to_err_count", 128'(err_cnt), 128'(1));
        b_read(M0, 32'h0000_0500, 32'h0BAD_F00D, "b_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Parametrised shared-memory arbiter for the riscv32i core. It merges NUM_MASTERS request channels onto one valid/ready memory bus: instruction fetch, data load/store, and optionally a debug/DMA port. It provides round-robin arbitration, one outstanding transaction, a bus timeout, and an access-fault report that the trap logic consumes next to the misalign flags. It sits between `riscv_core` and external memory, replacing the direct `instr`/`mem_rd_data` wiring.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8; BE_W = DATA_W/8
- NUM_MASTERS, 2, requesting channels, 1..8; index 0 = instruction fetch
- TIMEOUT, 255, maximum cycles from bus_valid to bus_rvalid before a fault; 1..65535

Ports (per-master buses are flattened, master i at bits [i*W +: W]):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- m_req  in  NUM_MASTERS  request pending; held until m_gnt
- m_we  in  NUM_MASTERS  1 = write, 0 = read
- m_addr  in  NUM_MASTERS*ADDR_W  byte address
- m_wdata  in  NUM_MASTERS*DATA_W  write data
- m_be  in  NUM_MASTERS*BE_W  byte enables (mem_width encoding)
- m_gnt  out  NUM_MASTERS  one-hot, one-cycle pulse: request accepted
- m_rvalid  out  NUM_MASTERS  one-hot, one-cycle pulse: response complete (reads and writes)
- m_rdata  out  DATA_W  response data, shared, valid with m_rvalid
- m_err  out  NUM_MASTERS  access fault, pulses together with m_rvalid
- bus_valid  out  1  request on bus
- bus_ready  in  1  bus accepts request
- bus_we  out  1  write
- bus_addr  out  ADDR_W  address
- bus_wdata  out  DATA_W  write data
- bus_be  out  BE_W  byte enables
- bus_rvalid  in  1  response valid
- bus_rdata  in  DATA_W  response data

## Operation
- FSM states: IDLE, ADDR, RESP, FAULT.
- IDLE:
  - If any m_req is high, choose the winner: the first requester at or after rr_ptr, scanning upward with wrap.
  - Assert m_gnt[winner] combinationally in that same cycle.
  - Latch we, addr, wdata, and be into request registers.
  - Set rr_ptr = (winner+1) mod NUM_MASTERS.
  - Go to ADDR if the latched be != 0; otherwise go to FAULT.
- ADDR: bus_valid=1 with the latched fields held stable. On bus_ready, go to RESP.
- RESP: wait for bus_rvalid. On bus_rvalid, register bus_rdata into m_rdata (writes register it too; masters ignore it), pulse m_rvalid[owner] the next cycle, and return to IDLE.
- FAULT: for one cycle, m_rvalid[owner]=1, m_err[owner]=1, m_rdata=0; then return to IDLE. No bus access is issued.
- Timeout:
  - A counter clears on entry to ADDR and increments every cycle in ADDR and RESP.
  - When it reaches TIMEOUT without bus_rvalid, go to FAULT, which reports m_err.
  - bus_valid drops in the cycle after the timeout.
- bus_rvalid outside RESP is ignored. bus_ready outside ADDR is ignored.
- m_gnt is asserted only in IDLE, so there is at most one outstanding transaction.
- NUM_MASTERS=1 degenerates to a pass-through with the timeout and fault behaviour retained. rr_ptr stays 0.

## Timing
Reset values (next edge with reset=1):
- state=IDLE, rr_ptr=0, counter=0
- m_gnt=0, m_rvalid=0, m_err=0, m_rdata=0
- bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0

Reset mid-transaction aborts at the next edge. No response is delivered to the owner, and bus_valid is low in the following cycle.

Minimum latency, with bus_ready and bus_rvalid each asserted at their first opportunity:
- Cycle 0: m_req, m_gnt.
- Cycle 1: bus_valid and bus_ready.
- Cycle 2: RESP and bus_rvalid.
- Cycle 3: m_rvalid.
- Next grant is possible in cycle 4 (IDLE).

Other timing rules:
- Zero-be fault: m_gnt in cycle 0, m_rvalid+m_err in cycle 1.
- A master keeping m_req high after m_rvalid is re-arbitrated against the others, so back-to-back service is not guaranteed.
- Simultaneous requests from all masters are served strictly in rotation.

## Test plan
- Single read, master 0, addr 0x0000_0100, be=4'hF. Bus ready and rvalid are immediate with rdata 0xDEAD_BEEF. Required: m_gnt[0] at cycle 0, bus_valid for 1 cycle, m_rvalid[0] at cycle 3, m_rdata=0xDEAD_BEEF, m_err=0.
- Both masters request continuously. Required grant order 0,1,0,1. After reset, master 1 requesting alone is granted immediately. After a master 1 grant, a simultaneous request is granted to master 0.
- bus_ready delayed 5 cycles and bus_rvalid delayed 3 more. Required: bus_addr, bus_wdata, bus_be, and bus_we stable throughout ADDR; m_rvalid[owner] exactly once, no m_err.
- TIMEOUT=8, bus_rvalid never asserted. Required: m_rvalid[1]=1, m_err[1]=1, m_rdata=0 at the fault cycle; FSM then back in IDLE with bus_valid=0; a subsequent request proceeds normally.
- Write with be=4'h0 from master 1. Required: bus_valid never asserts, m_err[1] and m_rvalid[1] in the cycle after m_gnt[1].
- Reset asserted while in RESP. Required: all outputs at reset values next cycle, no m_rvalid, rr_ptr=0 (a master 0 and master 1 collision is then granted to master 0).
